// File: rtl/alu_uop_decoder_pkg.sv
// Shared decode constants for the ALU uop decoder: opcodes, funct fields,
// class bit indices and control codes.
package alu_uop_pkg;

    localparam int CTRL_W = 5;
    localparam int CLS_W  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int CLS_ADD    = 0;
    localparam int CLS_LOGIC  = 1;
    localparam int CLS_SHIFT  = 2;
    localparam int CLS_CMP    = 3;
    localparam int CLS_BRANCH = 4;

    typedef enum logic [CTRL_W-1:0] {
        CTRL_NONE = 5'd0,  CTRL_ADD  = 5'd1,  CTRL_SUB  = 5'd2,  CTRL_AND  = 5'd3,
        CTRL_OR   = 5'd4,  CTRL_XOR  = 5'd5,  CTRL_SLL  = 5'd6,  CTRL_SRL  = 5'd7,
        CTRL_SRA  = 5'd8,  CTRL_SLT  = 5'd9,  CTRL_SLTU = 5'd10, CTRL_BEQ  = 5'd11,
        CTRL_BNE  = 5'd12, CTRL_BLT  = 5'd13, CTRL_BGE  = 5'd14, CTRL_BLTU = 5'd15,
        CTRL_BGEU = 5'd16, CTRL_JAL  = 5'd17, CTRL_JALR = 5'd18
    } ctrl_e;

    typedef struct packed {
        logic [CLS_W-1:0] cls;
        ctrl_e            ctrl;
        logic             imm;
        logic             illegal;
    } uop_dec_t;

    function automatic logic [CLS_W-1:0] ctrl_class(input ctrl_e c);
        logic [CLS_W-1:0] r;
        r = '0;
        case (c)
            CTRL_ADD, CTRL_SUB:                    r[CLS_ADD]    = 1'b1;
            CTRL_AND, CTRL_OR, CTRL_XOR:           r[CLS_LOGIC]  = 1'b1;
            CTRL_SLL, CTRL_SRL, CTRL_SRA:          r[CLS_SHIFT]  = 1'b1;
            CTRL_SLT, CTRL_SLTU:                   r[CLS_CMP]    = 1'b1;
            CTRL_BEQ, CTRL_BNE, CTRL_BLT, CTRL_BGE,
            CTRL_BLTU, CTRL_BGEU, CTRL_JAL, CTRL_JALR: r[CLS_BRANCH] = 1'b1;
            default:                               r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_uop_decoder_if.sv
// Input-bundle / output-bundle handshake bus of the ALU uop decoder.
// master drives bundles and out_ready; slave is the decoder.
interface alu_uop_decoder_if #(parameter int LANES = 2);
    import alu_uop_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_en;
    logic [7*LANES-1:0]      in_opcode;
    logic [3*LANES-1:0]      in_funct3;
    logic [7*LANES-1:0]      in_funct7;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [CLS_W*LANES-1:0]  out_class;
    logic [CTRL_W*LANES-1:0] out_ctrl;
    logic [LANES-1:0]        out_imm;
    logic [LANES-1:0]        out_illegal;

    modport master (
        output in_valid, in_lane_en, in_opcode, in_funct3, in_funct7, flush, out_ready,
        input  in_ready, out_valid, out_class, out_ctrl, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_lane_en, in_opcode, in_funct3, in_funct7, flush, out_ready,
        output in_ready, out_valid, out_class, out_ctrl, out_imm, out_illegal
    );

endinterface

// File: rtl/alu_uop_decoder_lane_dec.sv
// Combinational decode of one uop lane into class / control / immediate flag.
// Disabled and illegal lanes produce all-zero class, ctrl and imm.
module alu_uop_lane_dec
    import alu_uop_pkg::*;
(
    input  logic       i_en,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output uop_dec_t   o_dec
);

    ctrl_e w_ctrl;
    logic  w_imm;
    logic  w_bad;
    logic  w_ok;

    always_comb begin
        w_ctrl = CTRL_NONE;
        w_imm  = 1'b0;
        w_bad  = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                if (i_funct7 == F7_BASE) begin
                    case (i_funct3)
                        F3_ADD:  w_ctrl = CTRL_ADD;
                        F3_SLL:  w_ctrl = CTRL_SLL;
                        F3_SLT:  w_ctrl = CTRL_SLT;
                        F3_SLTU: w_ctrl = CTRL_SLTU;
                        F3_XOR:  w_ctrl = CTRL_XOR;
                        F3_SR:   w_ctrl = CTRL_SRL;
                        F3_OR:   w_ctrl = CTRL_OR;
                        default: w_ctrl = CTRL_AND;
                    endcase
                end else if (i_funct7 == F7_ALT && i_funct3 == F3_ADD) begin
                    w_ctrl = CTRL_SUB;
                end else if (i_funct7 == F7_ALT && i_funct3 == F3_SR) begin
                    w_ctrl = CTRL_SRA;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // funct7 only qualifies the shift-immediate forms
                w_imm = 1'b1;
                case (i_funct3)
                    F3_ADD:  w_ctrl = CTRL_ADD;
                    F3_SLT:  w_ctrl = CTRL_SLT;
                    F3_SLTU: w_ctrl = CTRL_SLTU;
                    F3_XOR:  w_ctrl = CTRL_XOR;
                    F3_OR:   w_ctrl = CTRL_OR;
                    F3_AND:  w_ctrl = CTRL_AND;
                    F3_SLL: begin
                        if (i_funct7 == F7_BASE) w_ctrl = CTRL_SLL;
                        else                     w_bad  = 1'b1;
                    end
                    default: begin
                        if (i_funct7 == F7_BASE)     w_ctrl = CTRL_SRL;
                        else if (i_funct7 == F7_ALT) w_ctrl = CTRL_SRA;
                        else                         w_bad  = 1'b1;
                    end
                endcase
            end
            OPC_BRANCH: begin
                case (i_funct3)
                    F3_BEQ:  w_ctrl = CTRL_BEQ;
                    F3_BNE:  w_ctrl = CTRL_BNE;
                    F3_BLT:  w_ctrl = CTRL_BLT;
                    F3_BGE:  w_ctrl = CTRL_BGE;
                    F3_BLTU: w_ctrl = CTRL_BLTU;
                    F3_BGEU: w_ctrl = CTRL_BGEU;
                    default: w_bad  = 1'b1;
                endcase
            end
            OPC_JAL: w_ctrl = CTRL_JAL;
            OPC_JALR: begin
                if (i_funct3 == F3_JALR) begin
                    w_ctrl = CTRL_JALR;
                    w_imm  = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_ok = i_en && !w_bad;

    always_comb begin
        o_dec         = '0;
        o_dec.illegal = i_en && w_bad;
        if (w_ok) begin
            o_dec.ctrl = w_ctrl;
            o_dec.cls  = ctrl_class(w_ctrl);
            o_dec.imm  = w_imm;
        end
    end

endmodule

// File: rtl/alu_uop_decoder.sv
// One-stage registered ALU uop decoder, LANES uops per bundle.
// Optional per-class performance counters under ALU_UOP_PERF_CNT_EN.
module alu_uop_decoder
    import alu_uop_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_uop_decoder_if.slave bus
`ifdef ALU_UOP_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_add,
    output logic [CNT_W-1:0] cnt_logic,
    output logic [CNT_W-1:0] cnt_shift,
    output logic [CNT_W-1:0] cnt_cmp,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_illegal
`endif
);

    uop_dec_t                         w_dec [LANES];
    logic                             w_in_ready;
    logic                             w_accept;

    logic                             r_vld;
    logic [LANES-1:0][CLS_W-1:0]      r_cls;
    logic [LANES-1:0][CTRL_W-1:0]     r_ctrl;
    logic [LANES-1:0]                 r_imm;
    logic [LANES-1:0]                 r_illegal;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_uop_lane_dec u_dec (
            .i_en     (bus.in_lane_en[g]),
            .i_opcode (bus.in_opcode[7*g +: 7]),
            .i_funct3 (bus.in_funct3[3*g +: 3]),
            .i_funct7 (bus.in_funct7[7*g +: 7]),
            .o_dec    (w_dec[g])
        );
    end

    // flush and reset both block acceptance so the bundle stays with the producer
    assign w_in_ready = !reset && !bus.flush && (!r_vld || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= 1'b0;
            r_cls     <= '0;
            r_ctrl    <= '0;
            r_imm     <= '0;
            r_illegal <= '0;
        end else if (bus.flush) begin
            r_vld <= 1'b0;
        end else if (w_accept) begin
            r_vld <= 1'b1;
            for (int l = 0; l < LANES; l++) begin
                r_cls[l]     <= w_dec[l].cls;
                r_ctrl[l]    <= w_dec[l].ctrl;
                r_imm[l]     <= w_dec[l].imm;
                r_illegal[l] <= w_dec[l].illegal;
            end
        end else if (r_vld && bus.out_ready) begin
            r_vld <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_vld;
    assign bus.out_class   = r_cls;
    assign bus.out_ctrl    = r_ctrl;
    assign bus.out_imm     = r_imm;
    assign bus.out_illegal = r_illegal;

`ifdef ALU_UOP_PERF_CNT_EN
    localparam int NCNT    = 6;
    localparam int CNT_ILL = 5;

    logic [NCNT-1:0][2:0]       w_inc;
    logic [NCNT-1:0][CNT_W:0]   w_sum;
    logic [NCNT-1:0][CNT_W-1:0] r_cnt;
    logic                       w_fire;

    assign w_fire = r_vld && bus.out_ready;

    always_comb begin
        w_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < CLS_W; k++)
                w_inc[k] = w_inc[k] + {2'b00, r_cls[l][k]};
            w_inc[CNT_ILL] = w_inc[CNT_ILL] + {2'b00, r_illegal[l]};
        end
        for (int k = 0; k < NCNT; k++)
            w_sum[k] = {1'b0, r_cnt[k]} + (CNT_W+1)'(w_inc[k]);
    end

    // a carry out of the counter width means saturate at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_fire) begin
            for (int k = 0; k < NCNT; k++)
                r_cnt[k] <= w_sum[k][CNT_W] ? {CNT_W{1'b1}} : w_sum[k][CNT_W-1:0];
        end
    end

    assign cnt_add     = r_cnt[CLS_ADD];
    assign cnt_logic   = r_cnt[CLS_LOGIC];
    assign cnt_shift   = r_cnt[CLS_SHIFT];
    assign cnt_cmp     = r_cnt[CLS_CMP];
    assign cnt_branch  = r_cnt[CLS_BRANCH];
    assign cnt_illegal = r_cnt[CNT_ILL];
`endif

endmodule
